// File: rtl/down_count_pkg.sv
// Shared types and constants for the down-counter sequencing controller.
package down_count_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StDone  = 2'b11
   } state_e;

   localparam int unsigned DefWidth = 4;
   localparam int unsigned DefDiv   = 1;

   // Prescaler is sized for DIV up to 16, so it counts at most 0..15.
   localparam int unsigned PreW = 4;

endpackage

// File: rtl/dc_prescaler.sv
// Step-rate divider: counts 0..DIV-1 while not held and strobes o_step on the last count.
module dc_prescaler
   import down_count_pkg::*;
#(
   parameter int unsigned DIV = DefDiv
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_hold,
   output logic o_step
);

   localparam logic [PreW-1:0] LastCnt = PreW'(DIV - 1);

   logic [PreW-1:0] r_cnt;
   logic [PreW-1:0] w_cnt_next;

   always_comb begin
      w_cnt_next = r_cnt;
      o_step     = 1'b0;
      if (i_clear) begin
         w_cnt_next = '0;
      end else if (!i_hold) begin
         if (r_cnt == LastCnt) begin
            o_step     = 1'b1;
            w_cnt_next = '0;
         end else begin
            w_cnt_next = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: rtl/down_count_ctrl.sv
// Down-counter sequencing controller: load, prescaled stepping, pause/abort, one-shot or reload.
// Optional live reload-value updates while counting: define DOWN_COUNT_CTRL_LIVE_RELOAD_EN.
module down_count_ctrl
   import down_count_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DIV   = DefDiv
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_pause,
   input  logic             i_abort,
   input  logic             i_periodic,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_reload_wr,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_tc,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_next;
   logic             r_periodic;
   logic             w_periodic_next;
   logic             r_tc;
   logic             w_tc_next;

   logic w_in_run;
   logic w_active;
   logic w_start_ok;
   logic w_step;

   assign w_in_run = (r_state == StRun) || (r_state == StPause);
   // Leaving PAUSE counts on the same edge, so a pause of N cycles delays by exactly N.
   assign w_active = w_in_run && !i_pause && !i_abort;
   // Pause outranks start, so a start coinciding with pause is dropped.
   assign w_start_ok = i_start && !i_abort && !i_pause &&
                       ((r_state == StIdle) || (r_state == StDone));

   dc_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .i_clear (i_abort || w_start_ok),
      .i_hold  (!w_active),
      .o_step  (w_step)
   );

`ifndef DOWN_COUNT_CTRL_LIVE_RELOAD_EN
   logic w_unused_reload_wr;
   assign w_unused_reload_wr = i_reload_wr;
`endif

   always_comb begin
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_reload_next   = r_reload;
      w_periodic_next = r_periodic;
      w_tc_next       = 1'b0;

      if (i_abort) begin
         w_state_next = StIdle;
         w_count_next = '0;
      end else begin
         unique case (r_state)
            StIdle, StDone: begin
               if (w_start_ok) begin
                  w_state_next    = StRun;
                  w_count_next    = i_load_val;
                  w_reload_next   = i_load_val;
                  w_periodic_next = i_periodic;
               end
            end
            StRun, StPause: begin
`ifdef DOWN_COUNT_CTRL_LIVE_RELOAD_EN
               // Takes effect at the next reload; the terminal step below still uses r_reload.
               if (i_reload_wr) begin
                  w_reload_next = i_load_val;
               end
`endif
               if (i_pause) begin
                  w_state_next = StPause;
               end else begin
                  w_state_next = StRun;
                  if (w_step) begin
                     if (r_count == CountOne) begin
                        w_tc_next = 1'b1;
                        if (r_periodic) begin
                           w_count_next = r_reload;
                        end else begin
                           w_count_next = '0;
                           w_state_next = StDone;
                        end
                     end else if (r_count == '0) begin
                        w_count_next = '1;
                     end else begin
                        w_count_next = r_count - 1'b1;
                     end
                  end
               end
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_count    <= '0;
         r_reload   <= '0;
         r_periodic <= 1'b0;
         r_tc       <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_count    <= w_count_next;
         r_reload   <= w_reload_next;
         r_periodic <= w_periodic_next;
         r_tc       <= w_tc_next;
      end
   end

   assign o_count = r_count;
   assign o_tc    = r_tc;
   assign o_busy  = w_in_run;
   assign o_done  = (r_state == StDone);

endmodule

// File: tb/tb_down_count_ctrl.sv
// Scoreboard bench for down_count_ctrl; DIV=1 and DIV=2 instances share one stimulus stream.
module tb_down_count_ctrl;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         busy;
      logic         tc;
      logic         done;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         pause;
   logic         abort;
   logic         periodic;
   logic         reload_wr;
   logic [W-1:0] load_val;

   logic [W-1:0] cnt1, cnt2;
   logic         busy1, tc1, done1;
   logic         busy2, tc2, done2;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   down_count_ctrl #(.WIDTH(W), .DIV(1)) u_div1 (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_pause     (pause),
      .i_abort     (abort),
      .i_periodic  (periodic),
      .i_load_val  (load_val),
      .i_reload_wr (reload_wr),
      .o_count     (cnt1),
      .o_busy      (busy1),
      .o_tc        (tc1),
      .o_done      (done1)
   );

   down_count_ctrl #(.WIDTH(W), .DIV(2)) u_div2 (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_pause     (pause),
      .i_abort     (abort),
      .i_periodic  (periodic),
      .i_load_val  (load_val),
      .i_reload_wr (reload_wr),
      .o_count     (cnt2),
      .o_busy      (busy2),
      .o_tc        (tc2),
      .o_done      (done2)
   );

   function automatic exp_t mk(int c, logic b, logic t, logic d);
      exp_t e;
      e.cnt  = W'(c);
      e.busy = b;
      e.tc   = t;
      e.done = d;
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_abort();
      start = 0; pause = 0; reload_wr = 0; abort = 1;
      cyc();
      abort = 0;
   endtask

   task automatic test_reset();
      exp_t e, g;
      rst = 1; start = 0; pause = 0; abort = 0; periodic = 0; reload_wr = 0; load_val = 0;
      cyc();
      cyc();
      rst = 0;
      g = mk(cnt1, busy1, tc1, done1);
      checks++;
      if (g !== mk(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_init: got cnt=%0d busy=%b tc=%b done=%b, want all zero",
                  g.cnt, g.busy, g.tc, g.done);
      end
      sb.push_back(mk(7, 1, 0, 0));
      for (int c = 6; c >= 4; c--) sb.push_back(mk(c, 1, 0, 0));
      for (int k = 0; k < 5; k++) sb.push_back(mk(0, 0, 0, 0));
      for (int i = 0; sb.size() > 0; i++) begin
         start = (i == 0); load_val = 7; periodic = 0;
         rst = (i == 4 || i == 5);
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL reset_midrun[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      rst = 0; start = 0;
   endtask

   task automatic test_oneshot();
      exp_t e, g;
      do_abort();
      for (int c = 5; c >= 1; c--) sb.push_back(mk(c, 1, 0, 0));
      sb.push_back(mk(0, 0, 1, 1));
      sb.push_back(mk(0, 0, 0, 1));
      sb.push_back(mk(0, 0, 0, 1));
      for (int i = 0; sb.size() > 0; i++) begin
         start = (i == 0); load_val = 5; periodic = 0;
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL oneshot[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0;
   endtask

   task automatic test_periodic_div2();
      exp_t e, g;
      do_abort();
      for (int p = 0; p < 2; p++) begin
         if (p == 0) sb.push_back(mk(3, 1, 0, 0));
         else        sb.push_back(mk(3, 1, 1, 0));
         sb.push_back(mk(3, 1, 0, 0));
         sb.push_back(mk(2, 1, 0, 0));
         sb.push_back(mk(2, 1, 0, 0));
         sb.push_back(mk(1, 1, 0, 0));
         sb.push_back(mk(1, 1, 0, 0));
      end
      sb.push_back(mk(3, 1, 1, 0));
      sb.push_back(mk(3, 1, 0, 0));
      for (int i = 0; sb.size() > 0; i++) begin
         start = (i == 0); load_val = 3; periodic = 1;
         cyc();
         e = sb.pop_front();
         g = mk(cnt2, busy2, tc2, done2);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL periodic_div2[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0; periodic = 0;
   endtask

   task automatic test_pause();
      exp_t e, g;
      do_abort();
      sb.push_back(mk(8, 1, 0, 0));
      sb.push_back(mk(7, 1, 0, 0));
      for (int k = 0; k < 5; k++) sb.push_back(mk(6, 1, 0, 0));
      for (int c = 5; c >= 1; c--) sb.push_back(mk(c, 1, 0, 0));
      sb.push_back(mk(0, 0, 1, 1));
      sb.push_back(mk(0, 0, 0, 1));
      for (int i = 0; sb.size() > 0; i++) begin
         start = (i == 0); load_val = 8; periodic = 0;
         pause = (i >= 3 && i <= 6);
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL pause[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0; pause = 0;
   endtask

   task automatic test_load_zero();
      exp_t e, g;
      do_abort();
      for (int k = 0; k < 16; k++) sb.push_back(mk((16 - k) % 16, 1, 0, 0));
      sb.push_back(mk(0, 0, 1, 1));
      sb.push_back(mk(0, 0, 0, 1));
      for (int i = 0; sb.size() > 0; i++) begin
         start = (i == 0); load_val = 0; periodic = 0;
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL load_zero[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0;
   endtask

   task automatic test_abort_start();
      exp_t e, g;
      do_abort();
      for (int c = 5; c >= 3; c--) sb.push_back(mk(c, 1, 0, 0));
      for (int k = 0; k < 3; k++) sb.push_back(mk(0, 0, 0, 0));
      for (int i = 0; sb.size() > 0; i++) begin
         load_val = 5; periodic = 1;
         start = (i == 0 || i == 3);
         abort = (i == 3);
         pause = (i == 3);
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL abort_start[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0; abort = 0; pause = 0; periodic = 0;
   endtask

   // Also confirms a start while counting is ignored.
   task automatic test_live_reload();
      exp_t e, g;
      int   cnt_tab[9];
      logic tc_tab[9];
`ifdef DOWN_COUNT_CTRL_LIVE_RELOAD_EN
      cnt_tab = '{5, 4, 3, 2, 1, 2, 1, 2, 1};
      tc_tab  = '{0, 0, 0, 0, 0, 1, 0, 1, 0};
`else
      cnt_tab = '{5, 4, 3, 2, 1, 5, 4, 3, 2};
      tc_tab  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
`endif
      do_abort();
      for (int k = 0; k < 9; k++) sb.push_back(mk(cnt_tab[k], 1, tc_tab[k], 0));
      for (int i = 0; sb.size() > 0; i++) begin
         periodic = 1;
         start = (i == 0 || i == 3);
         reload_wr = (i == 2);
         load_val = (i < 2) ? 4'd5 : (i == 2) ? 4'd2 : 4'd9;
         cyc();
         e = sb.pop_front();
         g = mk(cnt1, busy1, tc1, done1);
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL live_reload[%0d]: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
                     i, g.cnt, g.busy, g.tc, g.done, e.cnt, e.busy, e.tc, e.done);
         end
      end
      start = 0; reload_wr = 0; periodic = 0;
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic_div2();
      test_pause();
      test_load_zero();
      test_abort_start();
      test_live_reload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
